fencei_seq_ctrl: RTL

FENCEI_SEQ_CTRL -- requirements
Module: fencei_seq_ctrl

---
 rtl/fencei_seq_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fencei_seq_ctrl.sv
// FENCE.I sequencer: drain store buffer, write back D-cache, invalidate I-cache, flush and redirect fetch.
// Latency: fencei_req to redir_valid is at least 5 cycles; each wait state lasts until its condition or ack arrives.
// Backpressure: busy stalls decode for the whole sequence; requests arriving while busy are dropped.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fencei_req, fencei_npc     one-cycle request from decode plus the PC of the following instruction
//   sb_empty                   store buffer empty
//   dc_wb_req / dc_wb_ack      D-cache writeback-all (level request, pulse ack)
//   ic_inv_req / ic_inv_ack    I-cache invalidate-all (level request, pulse ack)
//   pipe_flush                 one-cycle flush of fetch/decode
//   redir_valid, redir_pc      one-cycle fetch redirect; redir_pc is zero when not valid
//   busy                       high in every state except IDLE
//   tmo_err                    sticky handshake timeout, only when HARVOS_FENCEI_TMO_EN is defined
//
// Optional feature macro: HARVOS_FENCEI_TMO_EN bounds each wait state to TMO_CYCLES cycles.
module fencei_seq_ctrl #(
    parameter int XLEN       = 32,
    parameter int TMO_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fencei_req,
    input  logic [XLEN-1:0] fencei_npc,
    input  logic            sb_empty,
    output logic            dc_wb_req,
    input  logic            dc_wb_ack,
    output logic            ic_inv_req,
    input  logic            ic_inv_ack,
    output logic            pipe_flush,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    output logic            busy
`ifdef HARVOS_FENCEI_TMO_EN
    ,
    output logic            tmo_err
`endif
);

    // A zero limit would make every wait state time out before it can be entered.
    if (TMO_CYCLES < 1) begin : g_bad_tmo
        $error("fencei_seq_ctrl: TMO_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_DCWB  = 3'd2,
        S_ICINV = 3'd3,
        S_FLUSH = 3'd4,
        S_REDIR = 3'd5
    } state_t;

    state_t          state_q;
    state_t          state_n;
    logic [XLEN-1:0] pc_q;
    logic            pc_load;

    // States that wait on an external condition; only these can time out.
    logic waiting;
    assign waiting = (state_q == S_DRAIN) || (state_q == S_DCWB) || (state_q == S_ICINV);

`ifdef HARVOS_FENCEI_TMO_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_hit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_n;
            if (pc_load) begin
                pc_q <= fencei_npc;
            end
        end
    end

    always_comb begin
        state_n     = state_q;
        pc_load     = 1'b0;
        dc_wb_req   = 1'b0;
        ic_inv_req  = 1'b0;
        pipe_flush  = 1'b0;
        redir_valid = 1'b0;
        busy        = 1'b1;
        // Acks are only looked at in the state that expects them, so stray
        // pulses elsewhere are dropped rather than remembered.
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (fencei_req) begin
                    pc_load = 1'b1;
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (sb_empty) begin
                    state_n = S_DCWB;
                end
            end
            S_DCWB: begin
                dc_wb_req = 1'b1;
                if (dc_wb_ack) begin
                    state_n = S_ICINV;
                end
            end
            S_ICINV: begin
                ic_inv_req = 1'b1;
                if (ic_inv_ack) begin
                    state_n = S_FLUSH;
                end
            end
            S_FLUSH: begin
                pipe_flush = 1'b1;
                state_n    = S_REDIR;
            end
            S_REDIR: begin
                // A fencei_req arriving here is dropped: we return to IDLE
                // without looking at it.
                redir_valid = 1'b1;
                state_n     = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = S_IDLE;
            end
        endcase
`ifdef HARVOS_FENCEI_TMO_EN
        // A normal exit wins over a timeout that lands on the same cycle.
        tmo_hit = waiting && (state_n == state_q) && (tmo_cnt == CW'(TMO_CYCLES - 1));
        if (tmo_hit) begin
            state_n = S_FLUSH;
        end
`endif
    end

    assign redir_pc = redir_valid ? pc_q : '0;

`ifdef HARVOS_FENCEI_TMO_EN
    // Counter restarts whenever the state changes, so each wait state gets
    // its own full budget of TMO_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (state_n != state_q) begin
                tmo_cnt <= '0;
            end else if (waiting) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                tmo_err <= 1'b1;
            end
        end
    end
`endif

endmodule
